// File: rtl/main_module_if.sv
// main_module_if: pixel handshake and window/result bus for main_module.
// master = frame source / consumer side, slave = the neighbourhood engine.
// fsm_state mirrors the engine's FSM register for observation.
interface main_module_if;
  logic        start;
  logic [7:0]  dataInput;
  logic        enable;
  logic [7:0]  out1;
  logic [7:0]  out2;
  logic [7:0]  out3;
  logic [7:0]  out4;
  logic [7:0]  out5;
  logic [7:0]  out6;
  logic [7:0]  out7;
  logic [7:0]  out8;
  logic [7:0]  out9;
  logic [31:0] doutb;
  logic        imageProcessed;
  logic [1:0]  fsm_state;

  modport master (
    output start, dataInput,
    input  enable, out1, out2, out3, out4, out5, out6, out7, out8, out9,
    input  doutb, imageProcessed, fsm_state
  );

  modport slave (
    input  start, dataInput,
    output enable, out1, out2, out3, out4, out5, out6, out7, out8, out9,
    output doutb, imageProcessed, fsm_state
  );
endinterface

// File: rtl/main_module.sv
// main_module: streaming 3x3 neighbourhood engine for IMG_W x IMG_H 8-bit frames.
// Requests pixels in raster order, keeps two line buffers and a zero-padded
// 3x3 window, and produces the window sum on doutb.
// Optional macro MAIN_MODULE_AVG_EN: doutb carries floor(sum/9) instead of the
// raw sum, with one extra pipeline stage.
//
// Handshake: enable is a registered request. The source presents the next
// pixel after every rising edge at which it sees enable=1; the engine captures
// dataInput one edge later, qualified by a one-cycle-delayed copy of enable.
module main_module #(
  parameter int IMG_W = 256,
  parameter int IMG_H = 256
) (
  input logic        mainClk,
  input logic        rst_n,
  main_module_if.slave bus
);
  localparam int TOTAL = IMG_W * IMG_H;
  localparam int CW    = $clog2(IMG_W);
  localparam int HW    = $clog2(IMG_H);
  localparam int QW    = $clog2(TOTAL);

  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [HW-1:0] ROW_LAST = HW'(IMG_H - 1);
  localparam logic [QW-1:0] REQ_LAST = QW'(TOTAL - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] LOAD = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]    state;
  logic          enable_r;
  logic [QW-1:0] req_cnt;
  logic          en_d;
  logic          cap;
  logic [CW-1:0] col;
  logic [HW-1:0] row;
  logic [7:0]    w1, w2, w3, w4, w5, w6, w7, w8, w9;
  logic [7:0]    lb1 [IMG_W];  // row r-1
  logic [7:0]    lb2 [IMG_W];  // row r-2
  logic          col_ok1, col_ok2, row_ok1, row_ok2;
  logic          last_cap;
  logic          cap_d1;
  logic          last_d1;
  logic          frame_done;
  logic [11:0]   sum;
  logic [31:0]   doutb_r;

  assign cap      = en_d;
  assign col_ok1  = (col != '0);
  assign col_ok2  = (col > CW'(1));
  assign row_ok1  = (row != '0);
  assign row_ok2  = (row > HW'(1));
  assign last_cap = cap && (col == COL_LAST) && (row == ROW_LAST);

  // Frame sequencing: request exactly TOTAL pixels, then wait for the last result.
  always_ff @(posedge mainClk) begin
    if (!rst_n) begin
      state    <= IDLE;
      enable_r <= 1'b0;
      req_cnt  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            state    <= LOAD;
            enable_r <= 1'b1;
            req_cnt  <= '0;
          end
        end
        LOAD: begin
          if (enable_r) begin
            req_cnt <= req_cnt + 1'b1;
            if (req_cnt == REQ_LAST) enable_r <= 1'b0;
          end
          if (frame_done) state <= DONE;
        end
        DONE: begin
          if (!bus.start) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Capture qualifier, raster position and zero-padded window shift.
  always_ff @(posedge mainClk) begin
    if (!rst_n) begin
      en_d <= 1'b0;
      col  <= '0;
      row  <= '0;
      w1 <= '0; w2 <= '0; w3 <= '0;
      w4 <= '0; w5 <= '0; w6 <= '0;
      w7 <= '0; w8 <= '0; w9 <= '0;
    end else begin
      en_d <= enable_r;
      if (cap) begin
        // Columns c-1 / c-2 are masked at the row start so nothing wraps
        // in from the previous row; rows above the frame read as zero.
        w9 <= bus.dataInput;
        w8 <= col_ok1 ? w9 : 8'd0;
        w7 <= col_ok2 ? w8 : 8'd0;
        w6 <= row_ok1 ? lb1[col] : 8'd0;
        w5 <= col_ok1 ? w6 : 8'd0;
        w4 <= col_ok2 ? w5 : 8'd0;
        w3 <= row_ok2 ? lb2[col] : 8'd0;
        w2 <= col_ok1 ? w3 : 8'd0;
        w1 <= col_ok2 ? w2 : 8'd0;
        if (col == COL_LAST) begin
          col <= '0;
          row <= row + 1'b1;
        end else begin
          col <= col + 1'b1;
        end
      end else if (state == IDLE) begin
        col <= '0;
        row <= '0;
      end
    end
  end

  // Line buffers: read-before-write per column; contents are never reset
  // because the window masking hides stale data.
  always_ff @(posedge mainClk) begin
    if (cap) begin
      lb2[col] <= lb1[col];
      lb1[col] <= bus.dataInput;
    end
  end

  // Nine-way window sum (max 9*255 = 2295 fits in 12 bits).
  always_comb begin
    sum = 12'(w1) + 12'(w2) + 12'(w3) + 12'(w4) + 12'(w5)
        + 12'(w6) + 12'(w7) + 12'(w8) + 12'(w9);
  end

  // Capture-valid and last-pixel markers one edge behind the window.
  always_ff @(posedge mainClk) begin
    if (!rst_n) begin
      cap_d1  <= 1'b0;
      last_d1 <= 1'b0;
    end else begin
      cap_d1  <= cap;
      last_d1 <= last_cap;
    end
  end

`ifdef MAIN_MODULE_AVG_EN
  logic        cap_d2;
  logic        last_d2;
  logic [11:0] sum_r;
  logic [23:0] prod;

  // sum*7282 >> 16 equals floor(sum/9) over the whole 0..2295 range.
  assign prod = {12'd0, sum_r} * 24'd7282;

  // Two-stage result: register the sum, then scale it.
  always_ff @(posedge mainClk) begin
    if (!rst_n) begin
      cap_d2  <= 1'b0;
      last_d2 <= 1'b0;
      sum_r   <= '0;
      doutb_r <= '0;
    end else begin
      cap_d2  <= cap_d1;
      last_d2 <= last_d1;
      if (cap_d1) sum_r <= sum;
      if (cap_d2) doutb_r <= 32'(prod >> 16);
    end
  end

  assign frame_done = last_d2;
`else
  // Single-stage result: raw sum, held between captures.
  always_ff @(posedge mainClk) begin
    if (!rst_n) begin
      doutb_r <= '0;
    end else if (cap_d1) begin
      doutb_r <= {20'd0, sum};
    end
  end

  assign frame_done = last_d1;
`endif

  assign bus.enable         = enable_r;
  assign bus.out1           = w1;
  assign bus.out2           = w2;
  assign bus.out3           = w3;
  assign bus.out4           = w4;
  assign bus.out5           = w5;
  assign bus.out6           = w6;
  assign bus.out7           = w7;
  assign bus.out8           = w8;
  assign bus.out9           = w9;
  assign bus.doutb          = doutb_r;
  assign bus.imageProcessed = (state == DONE);
  assign bus.fsm_state      = state;
endmodule

// File: tb/tb_main_module.sv
// tb_main_module: scoreboard bench for main_module on a reduced 64x32 frame.
// The source process pushes the expected window and result for every pixel it
// supplies; the monitor pops and compares when the DUT presents them.
module tb_main_module;
  localparam int W     = 64;
  localparam int H     = 32;
  localparam int TOTAL = W * H;
`ifdef MAIN_MODULE_AVG_EN
  localparam int AVG = 1;
`else
  localparam int AVG = 0;
`endif
  localparam int DL = 3 + AVG;  // result lag behind the enable sample

  // clock / reset
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  main_module_if bus();

  main_module #(.IMG_W(W), .IMG_H(H)) dut (
    .mainClk (clk),
    .rst_n   (rst_n),
    .bus     (bus)
  );

  int checks  = 0;
  int passed  = 0;
  int pidx    = 0;
  int cap_cnt = 0;
  logic        en_s = 1'b0;
  logic [7:0]  img [TOTAL];
  logic [71:0] exp_q[$];
  logic [31:0] exp_dout_q[$];
  logic [31:0] last_dout = '0;

  task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  function automatic logic [7:0] pix(input int r, input int c);
    if (r < 0 || c < 0) return 8'd0;
    return img[r * W + c];
  endfunction

  // Reference model: window and filter result for raster index p.
  task automatic push_expected(input int p);
    int r, c, s;
    logic [71:0] win;
    logic [7:0]  v;
    r = p / W;
    c = p % W;
    s = 0;
    win = '0;
    for (int dr = 2; dr >= 0; dr--) begin
      for (int dc = 2; dc >= 0; dc--) begin
        v   = pix(r - dr, c - dc);
        win = {win[63:0], v};
        s  += int'(v);
      end
    end
    exp_q.push_back(win);
    exp_dout_q.push_back(AVG ? 32'(s / 9) : 32'(s));
  endtask

  task automatic fill_image(input int mode);
    for (int i = 0; i < TOTAL; i++) begin
      case (mode)
        0:       img[i] = 8'hFF;
        1:       img[i] = 8'(i % W);
        default: img[i] = 8'($urandom_range(0, 255));
      endcase
    end
  endtask

  // enable as seen by the source at the next rising edge
  initial forever begin
    @(negedge clk);
    en_s = bus.enable;
  end

  // pixel source driver
  initial forever begin
    @(posedge clk);
    if (!rst_n) begin
      pidx = 0;
    end else if (en_s) begin
      #1;
      bus.dataInput = img[pidx % TOTAL];
      push_expected(pidx % TOTAL);
      pidx++;
    end
  end

  // monitor / scoreboard
  initial begin
    logic [7:0]  eh;
    logic        rst_seen;
    logic [71:0] win_act;
    logic [71:0] win_exp;
    logic [31:0] d_exp;
    eh = '0;
    rst_seen = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        if (rst_seen) begin
          chk("rst_enable", bus.enable, 0);
          chk("rst_done", bus.imageProcessed, 0);
          chk("rst_doutb", bus.doutb, 0);
          chk("rst_window", {bus.out1, bus.out2, bus.out3, bus.out4, bus.out5,
                             bus.out6, bus.out7, bus.out8, bus.out9}, 0);
        end
        rst_seen  = 1'b1;
        eh        = '0;
        last_dout = '0;
        exp_q.delete();
        exp_dout_q.delete();
      end else begin
        rst_seen = 1'b0;
        eh = {eh[6:0], bus.enable};
        if (eh[2]) begin
          win_act = {bus.out1, bus.out2, bus.out3, bus.out4, bus.out5,
                     bus.out6, bus.out7, bus.out8, bus.out9};
          if (exp_q.size() == 0) begin
            checks++;
            $display("FAIL window_pop: got window 0x%0h, expected no capture (queue empty)", win_act);
          end else begin
            win_exp = exp_q.pop_front();
            chk("window", win_act, win_exp);
          end
          cap_cnt++;
        end
        if (eh[DL]) begin
          if (exp_dout_q.size() == 0) begin
            checks++;
            $display("FAIL doutb_pop: got 0x%0h, expected no result (queue empty)", bus.doutb);
          end else begin
            d_exp = exp_dout_q.pop_front();
            chk("doutb", bus.doutb, d_exp);
            last_dout = d_exp;
          end
        end else begin
          chk("doutb_hold", bus.doutb, last_dout);
        end
      end
    end
  end

  task automatic run_frame(input int mode);
    int first, en_cnt, done_t;
    fill_image(mode);
    pidx    = 0;
    cap_cnt = 0;
    @(negedge clk);
    bus.start = 1'b1;
    chk("enable_before_start", bus.enable, 0);
    first  = -1;
    en_cnt = 0;
    done_t = -1;
    for (int t = 0; t < TOTAL + 40; t++) begin
      @(negedge clk);
      if (bus.enable) begin
        en_cnt++;
        if (first < 0) first = t;
      end
      if (bus.imageProcessed) begin
        done_t = t;
        break;
      end
    end
    chk("enable_rise", 72'(first), 72'(0));
    chk("enable_cycles", 72'(en_cnt), 72'(TOTAL));
    chk("done_time", 72'(done_t), 72'(TOTAL + 2 + AVG));
    repeat (10) begin
      @(negedge clk);
      chk("done_hold", bus.imageProcessed, 1);
      chk("no_rerequest", bus.enable, 0);
    end
    chk("frame_captures", 72'(cap_cnt), 72'(TOTAL));
    bus.start = 1'b0;
    @(negedge clk);
    chk("done_clear", bus.imageProcessed, 0);
  endtask

  task automatic abort_frame();
    fill_image(2);
    pidx    = 0;
    cap_cnt = 0;
    @(negedge clk);
    bus.start = 1'b1;
    for (int t = 0; t < TOTAL + 40; t++) begin
      @(negedge clk);
      if (cap_cnt >= 1000) break;
    end
    chk("abort_reached", 72'(cap_cnt >= 1000), 72'(1));
    @(posedge clk);
    #2;
    rst_n     = 1'b0;
    bus.start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("abort_enable", bus.enable, 0);
    chk("abort_out9", bus.out9, 0);
    chk("abort_doutb", bus.doutb, 0);
    chk("abort_done", bus.imageProcessed, 0);
  endtask

  // main sequence
  initial begin
    bus.start     = 1'b0;
    bus.dataInput = 8'd0;
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b1;
    run_frame(0);
    run_frame(1);
    run_frame(2);
    abort_frame();
    run_frame(2);
    run_frame(1);
    repeat (5) @(negedge clk);
    chk("queue_empty", 72'(exp_q.size() + exp_dout_q.size()), 72'(0));
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
